// File: rtl/spi_1_0_shift_engine.sv
// ---------------------------------------------------------------------------
// spi_1_0_shift_engine
//
// SPI mode-0 master shift engine. Accepts a command (tx word, bit length,
// start strobe) from the register bank, drives SPI_CS / SPI_SCK / SPI_MOSI,
// captures SPI_MISO and returns the received word. Every output is a flop.
//
// Ports:
//   clk, rstn           single clock, asynchronous active-low reset
//   start               one-cycle command strobe (accepted only when idle)
//   len [LENW]          frame length in bits; 0 ignored, >DW clamped to DW
//   tx_data [DW]        transmit word, right-justified, bit len-1 sent first
//   busy                high from the cycle after acceptance through FSM_DONE
//   rx_data [DW]        received word, right-justified, zeros above len
//   rx_valid            one-cycle strobe, coincident with FSM_DONE
//   FSM_START/FSM_DONE  one-cycle frame begun / frame complete strobes
//   SPI_MISO            serial input (already synchronised)
//   SPI_MOSI/SCK/CS     serial output, serial clock (idles low), chip select
//   dbg_state [3]       current FSM state, for observation only
//
// Handshake: there is no ready. start is sampled only in IDLE; a start seen
// in any other state (busy=1) is dropped, nothing is queued. The frame that
// a start launches is acknowledged by FSM_START one cycle later and closed
// by FSM_DONE/rx_valid; the cycle after FSM_DONE is IDLE and takes a new
// start.
// ---------------------------------------------------------------------------
module spi_1_0_shift_engine #(
    parameter int DW       = 32,
    parameter int LENW     = 6,
    parameter int SCK_DIV  = 2,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [LENW-1:0] len,
    input  logic [DW-1:0]   tx_data,
    output logic            busy,
    output logic [DW-1:0]   rx_data,
    output logic            rx_valid,
    output logic            FSM_START,
    output logic            FSM_DONE,
    input  logic            SPI_MISO,
    output logic            SPI_MOSI,
    output logic            SPI_SCK,
    output logic            SPI_CS,
    output logic [2:0]      dbg_state
);

    // One shared phase counter covers SETUP, each SCK half-period and HOLD,
    // so it is sized for the longest of the three.
    localparam int CNT_M1  = (SCK_DIV > CS_SETUP) ? SCK_DIV : CS_SETUP;
    localparam int CNT_MAX = (CNT_M1 > CS_HOLD) ? CNT_M1 : CS_HOLD;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] DIV_LAST   = CW'(SCK_DIV - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SETUP    = 3'd1,
        S_SHIFT_LO = 3'd2,
        S_SHIFT_HI = 3'd3,
        S_HOLD     = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t          state_q,    state_d;
    logic [CW-1:0]   cnt_q,      cnt_d;
    logic [LENW-1:0] bits_q,     bits_d;
    logic [DW-1:0]   tx_sh_q,    tx_sh_d;
    logic [DW-1:0]   rx_sh_q,    rx_sh_d;
    logic [DW-1:0]   rx_data_q,  rx_data_d;
    logic            cs_q,       cs_d;
    logic            sck_q,      sck_d;
    logic            mosi_q,     mosi_d;
    logic            busy_q,     busy_d;
    logic            rx_valid_q, rx_valid_d;
    logic            fstart_q,   fstart_d;
    logic            fdone_q,    fdone_d;

    logic [LENW-1:0] eff_len;
    logic [LENW-1:0] align_sh;
    logic [DW-1:0]   tx_aligned;

    // Clamp the length, then left-align the tx word so the first bit to send
    // always sits in the MSB of the shift register.
    always_comb begin
        eff_len    = (len > LENW'(DW)) ? LENW'(DW) : len;
        align_sh   = LENW'(DW) - eff_len;
        tx_aligned = tx_data << align_sh;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bits_d     = bits_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        cs_d       = cs_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        busy_d     = busy_q;
        rx_valid_d = 1'b0;
        fstart_d   = 1'b0;
        fdone_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && (len != '0)) begin
                    state_d  = S_SETUP;
                    cnt_d    = '0;
                    bits_d   = eff_len;
                    tx_sh_d  = tx_aligned;
                    rx_sh_d  = '0;
                    cs_d     = 1'b0;
                    mosi_d   = tx_aligned[DW-1];
                    busy_d   = 1'b1;
                    fstart_d = 1'b1;
                end
            end

            S_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = S_SHIFT_LO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_SHIFT_LO: begin
                if (cnt_q == DIV_LAST) begin
                    // SCK rises with this update; MISO is captured here.
                    state_d = S_SHIFT_HI;
                    cnt_d   = '0;
                    sck_d   = 1'b1;
                    rx_sh_d = {rx_sh_q[DW-2:0], SPI_MISO};
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_SHIFT_HI: begin
                if (cnt_q == DIV_LAST) begin
                    // SCK falls with this update; the bit just sampled by the
                    // slave is retired and MOSI moves to the next one.
                    cnt_d   = '0;
                    sck_d   = 1'b0;
                    bits_d  = bits_q - LENW'(1);
                    tx_sh_d = tx_sh_q << 1;
                    if (bits_q != LENW'(1)) begin
                        mosi_d  = tx_sh_q[DW-2];
                        state_d = S_SHIFT_LO;
                    end else begin
                        mosi_d  = 1'b0;
                        state_d = S_HOLD;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    // Only eff_len bits were shifted into a cleared register,
                    // so the bits above eff_len are already zero.
                    state_d    = S_DONE;
                    cnt_d      = '0;
                    cs_d       = 1'b1;
                    fdone_d    = 1'b1;
                    rx_valid_d = 1'b1;
                    rx_data_d  = rx_sh_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
                cs_d    = 1'b1;
                sck_d   = 1'b0;
                mosi_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bits_q     <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            cs_q       <= 1'b1;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            fstart_q   <= 1'b0;
            fdone_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bits_q     <= bits_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            cs_q       <= cs_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            rx_valid_q <= rx_valid_d;
            fstart_q   <= fstart_d;
            fdone_q    <= fdone_d;
        end
    end

    assign busy      = busy_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign FSM_START = fstart_q;
    assign FSM_DONE  = fdone_q;
    assign SPI_MOSI  = mosi_q;
    assign SPI_SCK   = sck_q;
    assign SPI_CS    = cs_q;
    assign dbg_state = state_q;

endmodule
